// File: rtl/filtr_sample_ctrl.sv
// Sample-side initiator for a filtr_a filter: 2-entry ADC FIFO, trig/done handshake, DAC strobe; FILTR_CTRL_TIMEOUT_EN adds a WAIT_DONE abort.
// ADC-to-DAC latency 5 cycles, 6-cycle sample period; no backpressure upstream, a push to a full FIFO drops the sample and sets overrun.
module filtr_sample_ctrl #(
  parameter int DATA_SIZE    = 24,
  parameter int GUARD_CYCLES = 2
`ifdef FILTR_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT    = 64
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [DATA_SIZE-1:0] filt_data_in,
  output logic                 sample_trig,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] filt_data_out,
  output logic [DATA_SIZE-1:0] dac_data,
  output logic                 dac_valid,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_DONE, CAPTURE, GUARD} state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] fifo_mem [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           fifo_cnt;
  logic                 fifo_empty, fifo_full;
  logic                 pop, push, drop;
  logic [GW-1:0]        guard_cnt;
  logic                 timed_out;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO is still taken then.
  assign push       = adc_valid && (!fifo_full || pop);
  assign drop       = adc_valid && fifo_full && !pop;

`ifdef FILTR_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] to_cnt;

  assign timed_out = (state == WAIT_DONE) && !filter_done && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == TRIG) begin
      to_cnt <= '0;
    end else if (state == WAIT_DONE && !filter_done) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop) state_nxt = TRIG;
      TRIG:      state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (filter_done)    state_nxt = CAPTURE;
        else if (timed_out) state_nxt = IDLE;
      end
      CAPTURE:   state_nxt = (GUARD_CYCLES == 0) ? IDLE : GUARD;
      GUARD:     if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= adc_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_data_in <= '0;
      sample_trig  <= 1'b0;
      dac_data     <= '0;
      dac_valid    <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      guard_cnt    <= '0;
    end else begin
      if (pop) filt_data_in <= fifo_mem[rd_ptr];
      sample_trig <= pop;
      if (state == CAPTURE) dac_data <= filt_data_out;
      dac_valid   <= (state == CAPTURE);
      overrun     <= overrun | drop;
      timeout_err <= timeout_err | timed_out;
      guard_cnt   <= (state == GUARD) ? guard_cnt + GW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_filtr_sample_ctrl.sv
// Directed bench for filtr_sample_ctrl: a queue scoreboard checks every dac_valid for data and cycle; a small filter model answers sample_trig.
module tb_filtr_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] adc_data;
  logic        adc_valid;
  logic [23:0] filt_data_in;
  logic        sample_trig;
  logic        filter_done;
  logic [23:0] filt_data_out;
  logic [23:0] dac_data;
  logic        dac_valid;
  logic        overrun;
  logic        timeout_err;

  logic        model_done;
  logic        spur_done;
  logic        mute;

  typedef struct {
    logic [23:0] d;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] resp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign filter_done = model_done | spur_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  filtr_sample_ctrl #(
    .DATA_SIZE(24),
    .GUARD_CYCLES(2)
`ifdef FILTR_CTRL_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .filt_data_in(filt_data_in),
    .sample_trig(sample_trig),
    .filter_done(filter_done),
    .filt_data_out(filt_data_out),
    .dac_data(dac_data),
    .dac_valid(dac_valid),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [23:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [23:0] r, input int c);
    exp_t e;
    e.d = r;
    e.c = c;
    resp_q.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    resp_q.delete();
  endtask

  // Filter model: done one cycle after trig, result valid the cycle after done.
  initial begin
    model_done    = 1'b0;
    filt_data_out = '0;
    forever begin
      @(negedge clk);
      if (sample_trig && !mute) begin
        @(posedge clk);
        #1 model_done = 1'b1;
        @(posedge clk);
        #1 model_done = 1'b0;
        filt_data_out = (resp_q.size() != 0) ? resp_q.pop_front() : 24'h0;
      end
    end
  end

  // Monitor: every dac_valid must match the head of the scoreboard in data and cycle.
  always @(negedge clk) begin
    if (dac_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_dac_valid: got dac_data=%h at cycle %0d, required no strobe", dac_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dac_data !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL dac_out: got %h at cycle %0d, required %h at cycle %0d", dac_data, cyc, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int  t0;
    bit  trig_seen;
    reset     = 1'b1;
    adc_valid = 1'b0;
    adc_data  = '0;
    spur_done = 1'b0;
    mute      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_sample_trig", sample_trig, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_filt_data_in", filt_data_in, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Single sample, with spurious done pulses in GUARD (c5) and IDLE (c7).
    t0 = cyc;
    expect_out(24'hABCDEF, t0 + 5);
    strobe(24'h123456);
    chk("trig_c1", sample_trig, 0);
    tick();
    for (int k = 2; k <= 8; k++) begin
      if (k <= 7) chk("filt_data_in_hold", filt_data_in, 32'h123456);
      chk("sample_trig_pulse", sample_trig, 32'(k == 2));
      spur_done = (k == 5 || k == 7);
      tick();
    end
    spur_done = 1'b0;
    chk("dac_data_hold", dac_data, 32'hABCDEF);
    wait_drain();

    // Three strobes c0..c2: the first is popped at c1, so the FIFO only fills at c3.
    // At c7 the IDLE pop and a new push collide on the full FIFO.
    reset_dut();
    t0 = cyc;
    expect_out(24'h111111, t0 + 5);
    expect_out(24'h222222, t0 + 11);
    expect_out(24'h333333, t0 + 17);
    expect_out(24'h444444, t0 + 23);
    strobe(24'h000001);
    strobe(24'h7FFFFF);
    strobe(24'h800000);
    repeat (4) tick();
    strobe(24'hFFFFFF);
    chk("collision_no_overrun", overrun, 0);
    chk("collision_fifo_order", filt_data_in, 32'h7FFFFF);
    wait_drain();
    chk("collision_overrun_end", overrun, 0);

    // Four strobes c0..c3: the fourth hits a full FIFO while busy and is dropped.
    reset_dut();
    t0 = cyc;
    expect_out(24'h0F0F0F, t0 + 5);
    expect_out(24'hF0F0F0, t0 + 11);
    expect_out(24'h5A5A5A, t0 + 17);
    strobe(24'h000010);
    strobe(24'h000020);
    strobe(24'h000030);
    chk("overrun_before_drop", overrun, 0);
    strobe(24'h000040);
    chk("overrun_after_drop", overrun, 1);
    wait_drain();
    chk("overrun_sticky", overrun, 1);

    // Reset at c3 of a transfer with a second sample queued.
    t0 = cyc;
    resp_q.push_back(24'hDEAD00);
    strobe(24'h00AAAA);
    strobe(24'h00BBBB);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_sample_trig", sample_trig, 0);
    chk("midrst_dac_valid", dac_valid, 0);
    chk("midrst_dac_data", dac_data, 0);
    chk("midrst_filt_data_in", filt_data_in, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    trig_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sample_trig) trig_seen = 1'b1;
      tick();
    end
    chk("midrst_no_retrigger", trig_seen, 0);
    resp_q.delete();

`ifdef FILTR_CTRL_TIMEOUT_EN
    // Muted filter: WAIT_DONE entered at c3, abort visible at c11, queued sample triggers at c12.
    t0 = cyc;
    mute = 1'b1;
    expect_out(24'h777777, t0 + 15);
    strobe(24'h010101);
    strobe(24'h020202);
    repeat (8) tick();
    chk("timeout_err_c10", timeout_err, 0);
    mute = 1'b0;
    tick();
    chk("timeout_err_c11", timeout_err, 1);
    tick();
    chk("timeout_next_trig", sample_trig, 1);
    chk("timeout_next_data", filt_data_in, 32'h020202);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
